cache_ctrl_param: RTL
=====================

# cache_ctrl_param

Parametrised direct-mapped, write-through cache controller with its tag/valid/data storage and line-fill sequencer in one block. It sits between the pipeline's fetch or memory stage and the multi-cycle memory model. It replaces the fixed 16-bit controller with configurable geometry, explicit memory read and write handshakes, bulk invalidate, and hit/miss performance counters.

## Interface
- ADDR_W, 16, byte-address width.
- DATA_W, 16, word width; multiple of 8.
- LINES, 8, number of lines; power of 2, ≥2.
- WORDS, 8, words per line; power of 2, ≥2.
- BYTE_OFF_W, 1, ignored low address bits; equals log2(DATA_W/8).
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  access presented this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- invalidate  in  1  clear all valid bits.
- rdata  out  DATA_W  read data; combinational from the data array.
- stall  out  1  request not completing this cycle.
- mem_rd_req  out  1  memory read issue strobe.
- mem_wr_req  out  1  write-through strobe.
- mem_addr  out  ADDR_W  memory address; fill address or write-through address.
- mem_wdata  out  DATA_W  write-through data.
- mem_rdata  in  DATA_W  fill data.
- mem_rvalid  in  1  mem_rdata valid; returns in issue order.
- hit_count, miss_count  out  16  saturating performance counters.

## Operation
- Address fields, LSB first: byte offset (BYTE_OFF_W), word offset (OFF_W = log2 WORDS), index (IDX_W = log2 LINES), tag (TAG_W = ADDR_W − IDX_W − OFF_W − BYTE_OFF_W). TAG_W must be ≥1.
- States: IDLE and FILL.
- IDLE, hit (valid[index] and tag match):
  - Read: rdata holds the addressed word; stall = 0.
  - Write: the data word is written at the clock edge. mem_wr_req = 1, with mem_addr = req_addr and mem_wdata = req_wdata in the same cycle.
  - hit_count increments by 1.
- IDLE, miss, with req_valid asserted:
  - stall = 1.
  - The line base address (offset bits zeroed) is latched; miss_count increments.
  - The FSM moves to FILL.
- FILL:
  - stall = 1.
  - Issue counter 0..WORDS−1: mem_rd_req = 1 and mem_addr = base + issue·(DATA_W/8), one word per cycle, until all WORDS are issued.
  - Each mem_rvalid writes mem_rdata into the next receive slot of the line.
  - On the WORDS-th mem_rvalid, the tag is written, valid is set, and the FSM returns to IDLE.
  - The held request then re-evaluates as a hit. A write completes and writes through at that point, so a write miss allocates.
- The requester holds req_* stable while stall = 1.
- mem_rvalid is ignored in IDLE.
- invalidate clears every valid bit at the clock edge.
  - In IDLE with a simultaneous request, the request is looked up against the pre-clear valid bits.
  - In FILL, the fill continues, and its line becomes valid on completion.
- Counters saturate at 16'hFFFF.

## Timing
- Reset values:
  - State IDLE; all valid bits 0; counters 0.
  - stall, mem_rd_req, mem_wr_req = 0.
  - mem_addr, mem_wdata = 0 when idle with no request.
  - rdata = 0 until written; the data array is cleared.
- Reset asserted mid-fill aborts the fill immediately (asynchronous); the partially filled line stays invalid.
- Hit latency is 0 cycles; stall, rdata and mem_wr_req are combinational.
- Miss penalty is 1 detect cycle plus fill cycles, through the cycle carrying the last mem_rvalid. The request completes in the following cycle.
- The controller is latency-agnostic: it counts mem_rvalid responses and never assumes a fixed memory latency.

## Structure
- Package cache_ctrl_pkg holds:
  - the state enum (IDLE, FILL);
  - the clog2 helper function;
  - the derived-width localparam formulas (OFF_W, IDX_W, TAG_W).
- One sub-module, line_fill_sequencer, holds:
  - the issue and receive counters;
  - base-address latch and mem_addr generation;
  - a done pulse.
- Tag, valid and data arrays and the hit logic live in the top module.

## Test plan
Defaults; memory returns 0xA000+k for word k, two cycles after issue. Address 0x1234 decodes to word 2, index 3, tag 0x24.
- Reset, then read 0x1234 -> stall = 1 in the same cycle; mem_rd_req with mem_addr 0x1230, 0x1232 … 0x123E over 8 consecutive cycles.
- Fill completes -> next cycle stall = 0 and rdata = 0xA002; hit_count = 1, miss_count = 1.
- Write 0x1236 with 0xBEEF on a hit -> stall = 0; mem_wr_req = 1 with mem_addr 0x1236 and mem_wdata 0xBEEF; a following read of 0x1236 returns 0xBEEF.
- Read 0x1A34 (same index, tag 0x34) -> miss and fill; a read of 0x1234 then misses again; miss_count = 3.
- Pulse invalidate, then read 0x1A34 -> miss. Write miss to 0x2000 with 0x5555 -> exactly one mem_wr_req (mem_addr 0x2000), only after the fill completes.
- Assert rst_n = 0 during the fill's fourth issue cycle -> mem_rd_req and stall drop immediately; after release, read 0x1230 misses.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// Shared types and geometry helpers for the parametrised cache controller.
// Derived address-field widths are computed here so every file agrees.
package cache_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int off_w(input int words);
    return clog2(words);
  endfunction

  function automatic int idx_w(input int lines);
    return clog2(lines);
  endfunction

  function automatic int tag_w(
    input int addr_w,
    input int lines,
    input int words,
    input int byte_off_w
  );
    return addr_w - clog2(lines) - clog2(words) - byte_off_w;
  endfunction

endpackage

// File: rtl/line_fill_sequencer.sv
// Line-fill sequencer: issues one word read per cycle from the latched
// line base and counts in-order responses into receive slots.
module line_fill_sequencer
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int WORDS      = 8,
  parameter int OFF_W      = 3,
  parameter int BYTE_OFF_W = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        active,
  input  logic [ADDR_W-OFF_W-BYTE_OFF_W-1:0] req_line,
  input  logic                        mem_rvalid,
  output logic                        mem_rd_req,
  output logic [ADDR_W-1:0]           fill_addr,
  output logic [ADDR_W-OFF_W-BYTE_OFF_W-1:0] fill_line,
  output logic [OFF_W-1:0]            rx_slot,
  output logic                        done
);

  localparam int LOW_W  = OFF_W + BYTE_OFF_W;
  localparam int LINE_W = ADDR_W - LOW_W;
  localparam logic [OFF_W:0]   N_ISSUE = (OFF_W + 1)'(WORDS);
  localparam logic [OFF_W-1:0] LAST    = OFF_W'(WORDS - 1);

  logic [OFF_W:0]    issue_cnt;
  logic [OFF_W-1:0]  rx_cnt;
  logic [LINE_W-1:0] base;

  // Latch the line on a miss, then advance issue/receive counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base      <= '0;
      issue_cnt <= '0;
      rx_cnt    <= '0;
    end else if (start) begin
      base      <= req_line;
      issue_cnt <= '0;
      rx_cnt    <= '0;
    end else if (active) begin
      if (mem_rd_req) issue_cnt <= issue_cnt + (OFF_W + 1)'(1);
      if (mem_rvalid) rx_cnt <= rx_cnt + OFF_W'(1);
    end
  end

  assign mem_rd_req = active && (issue_cnt < N_ISSUE);
  assign fill_addr  = {base, issue_cnt[OFF_W-1:0], {BYTE_OFF_W{1'b0}}};
  assign fill_line  = base;
  assign rx_slot    = rx_cnt;
  assign done       = active && mem_rvalid && (rx_cnt == LAST);

endmodule

// File: rtl/cache_ctrl_param.sv
// Direct-mapped write-through cache controller with tag/valid/data
// storage, hit logic, fill FSM and saturating hit/miss counters.
module cache_ctrl_param
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int LINES      = 8,
  parameter int WORDS      = 8,
  parameter int BYTE_OFF_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              invalidate,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);

  localparam int OFF_W  = off_w(WORDS);
  localparam int IDX_W  = idx_w(LINES);
  localparam int TAG_W  = tag_w(ADDR_W, LINES, WORDS, BYTE_OFF_W);
  localparam int LOW_W  = OFF_W + BYTE_OFF_W;
  localparam int LINE_W = ADDR_W - LOW_W;

  state_t state, state_nx;

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_arr  [LINES];
  logic [DATA_W-1:0] data_arr [LINES][WORDS];

  logic [OFF_W-1:0]  req_off;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [LINE_W-1:0] fill_line;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;
  logic [OFF_W-1:0]  rx_slot;
  logic [ADDR_W-1:0] fill_addr;
  logic hit, acc_hit, acc_miss, wr_hit;
  logic fill_active, fill_done;

  assign req_off     = req_addr[LOW_W-1:BYTE_OFF_W];
  assign req_idx     = req_addr[LOW_W+IDX_W-1:LOW_W];
  assign req_tag     = req_addr[ADDR_W-1:LOW_W+IDX_W];
  assign fill_idx    = fill_line[IDX_W-1:0];
  assign fill_tag    = fill_line[LINE_W-1:IDX_W];
  assign fill_active = (state == FILL);
  assign hit         = valid[req_idx] && (tag_arr[req_idx] == req_tag);
  assign acc_hit     = !fill_active && req_valid && hit;
  assign acc_miss    = !fill_active && req_valid && !hit;
  assign wr_hit      = acc_hit && req_write;
  assign rdata       = data_arr[req_idx][req_off];

  line_fill_sequencer #(
    .ADDR_W     (ADDR_W),
    .WORDS      (WORDS),
    .OFF_W      (OFF_W),
    .BYTE_OFF_W (BYTE_OFF_W)
  ) u_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (acc_miss),
    .active     (fill_active),
    .req_line   (req_addr[ADDR_W-1:LOW_W]),
    .mem_rvalid (mem_rvalid),
    .mem_rd_req (mem_rd_req),
    .fill_addr  (fill_addr),
    .fill_line  (fill_line),
    .rx_slot    (rx_slot),
    .done       (fill_done)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and stall
  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    unique case (state)
      IDLE: begin
        stall = acc_miss;
        if (acc_miss) state_nx = FILL;
      end
      FILL: begin
        stall = 1'b1;
        if (fill_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Memory port: write-through on a write hit, else fill reads
  always_comb begin
    mem_wr_req = wr_hit;
    mem_wdata  = '0;
    mem_addr   = '0;
    if (wr_hit) begin
      mem_addr  = req_addr;
      mem_wdata = req_wdata;
    end else if (mem_rd_req) begin
      mem_addr = fill_addr;
    end
  end

  // Valid bits and tags; a completing fill wins over a bulk clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      for (int i = 0; i < LINES; i++) tag_arr[i] <= '0;
    end else begin
      if (invalidate) valid <= '0;
      if (fill_done) begin
        valid[fill_idx]   <= 1'b1;
        tag_arr[fill_idx] <= fill_tag;
      end
    end
  end

  // Data array: fill responses and write hits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LINES; i++)
        for (int j = 0; j < WORDS; j++)
          data_arr[i][j] <= '0;
    end else begin
      if (fill_active && mem_rvalid)
        data_arr[fill_idx][rx_slot] <= mem_rdata;
      if (wr_hit)
        data_arr[req_idx][req_off] <= req_wdata;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (acc_hit && hit_count != 16'hFFFF)
        hit_count <= hit_count + 16'd1;
      if (acc_miss && miss_count != 16'hFFFF)
        miss_count <= miss_count + 16'd1;
    end
  end

endmodule
